ring_fsm: RTL and testbench
===========================

# ring_fsm

Parametrised ring state machine with registered state. Generalises the team's 3-state next-state selector to N states. Each state advances to its successor when its own advance condition is true, and the last state wraps to state 0. Adds an enable, a synchronous load, a wrap pulse and an optional per-state dwell timeout. It is used as the sequencing core for round-robin controllers in the FSM test designs.

## Interface
- N, default 3: number of states, legal range 2..16.
- W, default $clog2(N): state encoding width. Derived; do not override.
- DWELL_W, default 8: width of the dwell counter and the timeout threshold.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset. Asserted when 0.
- en  in  1  global enable. When 0, state, dwell and wrap hold, except that wrap clears (see Operation).
- adv  in  N  per-state advance condition. Only bit adv[state] is consulted.
- load  in  1  synchronous load request. Qualified by en.
- load_state  in  W  target state for load.
- timeout_cyc  in  DWELL_W  dwell limit in cycles. 0 disables the timeout. Ignored when the timeout feature is compiled out.
- state  out  W  current registered state.
- next  out  W  combinational value that state will take at the next edge.
- onehot  out  N  registered one-hot decode of state.
- wrap  out  1  one-cycle pulse, high in the first cycle after an N-1 to 0 advance.
- dwell  out  DWELL_W  cycles spent in the current state. Tied to 0 when the timeout feature is compiled out.

## Operation
- The next-state priority evaluated when en=1 is:
  1. load: next = load_state if load_state < N, otherwise 0.
  2. Advance: adv[state] is 1, or a timeout fires. next = 0 if state == N-1, otherwise state+1.
  3. Otherwise: next = state.
- When en=0, next = state.
- adv bits other than adv[state] have no effect.
- wrap:
  - Registered. Set for exactly one cycle after an edge that advances from N-1 to 0 through rule 2.
  - A load to 0 never sets wrap. A load from N-1 does not set wrap either.
  - Cleared on any other edge, including edges where en=0.
- dwell (feature enabled):
  - Resets to 0 on any edge where state changes or load is applied, including a load to the current state.
  - Otherwise increments when en=1 and saturates at all-ones.
  - Holds when en=0.
- A timeout fires when en=1, timeout_cyc != 0 and dwell == timeout_cyc-1. The forced advance follows rule 2, so it can produce wrap.
- With timeout_cyc=1 the block advances every enabled cycle.
- timeout_cyc may change at any time. A new value takes effect in the same cycle by comparison.
- If timeout_cyc-1 is below the current dwell, no timeout fires until the next state change.
- Values outside 0..N-1 are unreachable in state.

## Timing
- Reset values: state=0, onehot=1 (bit 0), wrap=0, dwell=0. next shows the combinational value from the current inputs.
- The reset assertion takes effect immediately. On deassertion the block is active from the first following rising edge.
- Latency: adv or load sampled at edge k makes state update visible after edge k. onehot updates in the same cycle as state. wrap is high in the cycle after edge k and clears after edge k+1.
- next has zero latency: it is a combinational function of state, en, adv, load, load_state and dwell/timeout_cyc.
- If reset is asserted during a dwell count or a wrap pulse, all registers return to their reset values at once.

## Configuration
- RING_FSM_TIMEOUT_EN:
  - Defined: the dwell counter, the timeout compare and the dwell output are live.
  - Undefined: no dwell register is built, timeout_cyc is unused, dwell is tied to 0, and advance comes from adv[state] only.
- The port list is identical in both builds.

## Structure
- ring_fsm_pkg holds:
  - the legal N range constants (RING_FSM_MIN_N=2, RING_FSM_MAX_N=16);
  - a state-width helper function;
  - an enumerated priority encoding for transition cause: HOLD, LOAD, ADV, TIMEOUT.
- One sub-module, ring_fsm_dwell, owns the dwell counter and the timeout compare. It is instantiated only under RING_FSM_TIMEOUT_EN. It outputs a timeout flag and the dwell value.
- The top module holds the state register, the next-state mux, the onehot decode and the wrap register.

## Test plan
- Reset and sequence, N=3, en=1: release reset, pulse adv[0], then adv[1], then adv[2]. Required: state goes 0, 1, 2, 0, and wrap is high only in the cycle after the return to 0.
- Masking: in state 1, drive adv=3'b101 for 4 cycles. Required: state stays 1 and dwell counts 0, 1, 2, 3.
- Load, N=5:
  - In state 2, drive load=1, load_state=4 together with adv[2]=1. Required: state=4, because load has priority over advance.
  - Then drive load_state=6. Required: state=0 and wrap=0.
- Enable hold: in state 1 with en=0, drive adv=all-ones for 5 cycles. Required: state=1 and dwell frozen. Then set en=1. Required: state=2 on the next edge.
- Timeout (macro defined), timeout_cyc=3, adv=0, N=3: Required: state changes every 3 cycles, 0, 1, 2, 0, with wrap after 2 to 0. With timeout_cyc=0: Required: state holds indefinitely.
- Reset mid-operation: assert reset while state=2 and dwell=5. Required: state=0, onehot=001, dwell=0 and wrap=0 without waiting for a clock edge.

Source files
------------

// File: rtl/ring_fsm_pkg.sv
// -----------------------------------------------------------------------------
// ring_fsm_pkg
// Shared definitions for the ring state machine:
//   - legal range of the state count N
//   - state encoding width helper
//   - transition cause encoding, listed in priority order
// -----------------------------------------------------------------------------
package ring_fsm_pkg;

  localparam int RING_FSM_MIN_N = 2;
  localparam int RING_FSM_MAX_N = 16;

  // Transition cause for the current cycle; LOAD outranks ADV, ADV outranks TIMEOUT.
  typedef enum logic [1:0] {
    CAUSE_HOLD    = 2'd0,
    CAUSE_LOAD    = 2'd1,
    CAUSE_ADV     = 2'd2,
    CAUSE_TIMEOUT = 2'd3
  } cause_e;

  // Encoding width for n states; never narrower than one bit.
  function automatic int ring_fsm_state_w(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/ring_fsm_dwell.sv
// -----------------------------------------------------------------------------
// ring_fsm_dwell
// Dwell counter and timeout compare for ring_fsm. Counts cycles spent in the
// current state, saturating at all-ones, and flags a timeout in the cycle
// where the count reaches timeout_cyc-1.
//
// Ports:
//   i_clk          rising-edge clock
//   i_rst_n        asynchronous active-low reset
//   i_en           global enable; counter holds when low
//   i_clear        restart the count at the next edge (state change or load)
//   i_timeout_cyc  dwell limit in cycles, 0 disables the timeout
//   o_timeout      combinational timeout flag
//   o_dwell        registered dwell count
// -----------------------------------------------------------------------------
module ring_fsm_dwell import ring_fsm_pkg::*; #(
  parameter int DWELL_W = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_en,
  input  logic               i_clear,
  input  logic [DWELL_W-1:0] i_timeout_cyc,
  output logic               o_timeout,
  output logic [DWELL_W-1:0] o_dwell
);

  localparam logic [DWELL_W-1:0] DWELL_MAX  = {DWELL_W{1'b1}};
  localparam logic [DWELL_W-1:0] DWELL_ZERO = {DWELL_W{1'b0}};
  localparam logic [DWELL_W-1:0] DWELL_ONE  = DWELL_W'(1);

  logic [DWELL_W-1:0] r_dwell;
  logic [DWELL_W-1:0] w_dwell_next;

  // Timeout compare: a limit below the current count simply never matches
  // until the count restarts on the next state change.
  always_comb begin
    o_timeout = 1'b0;
    if (i_en && (i_timeout_cyc != DWELL_ZERO)) begin
      o_timeout = (r_dwell == (i_timeout_cyc - DWELL_ONE));
    end else begin
      o_timeout = 1'b0;
    end
  end

  // Next dwell value: restart, saturating increment or hold.
  always_comb begin
    w_dwell_next = r_dwell;
    if (!i_en) begin
      w_dwell_next = r_dwell;
    end else if (i_clear) begin
      w_dwell_next = DWELL_ZERO;
    end else if (r_dwell != DWELL_MAX) begin
      w_dwell_next = r_dwell + DWELL_ONE;
    end else begin
      w_dwell_next = r_dwell;
    end
  end

  // Dwell count register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dwell <= DWELL_ZERO;
    end else begin
      r_dwell <= w_dwell_next;
    end
  end

  assign o_dwell = r_dwell;

endmodule

// File: rtl/ring_fsm.sv
// -----------------------------------------------------------------------------
// ring_fsm
// Parametrised N-state ring sequencer. State k advances to k+1 (N-1 wraps to
// 0) when adv[k] is set or, in the timeout build, when the dwell limit is
// reached. A synchronous load overrides advance. A one-cycle wrap pulse marks
// each N-1 -> 0 advance.
//
// Build option:
//   RING_FSM_TIMEOUT_EN  defined: dwell counter and timeout are live.
//                        undefined: o_dwell is 0 and i_timeout_cyc is unused.
//
// Parameters: N (2..16 states), W (state width, derived), DWELL_W.
// Ports:
//   i_clk          rising-edge clock
//   i_rst_n        asynchronous active-low reset
//   i_en           global enable
//   i_adv          per-state advance condition, only i_adv[state] is used
//   i_load         synchronous load request (qualified by i_en)
//   i_load_state   load target; values >= N load state 0
//   i_timeout_cyc  dwell limit in cycles, 0 disables
//   o_state        registered state
//   o_next         combinational next state
//   o_onehot       registered one-hot decode of state
//   o_wrap         registered wrap pulse
//   o_dwell        cycles spent in the current state
// -----------------------------------------------------------------------------
module ring_fsm import ring_fsm_pkg::*; #(
  parameter int N       = 3,
  parameter int W       = ring_fsm_state_w(N),
  parameter int DWELL_W = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_en,
  input  logic [N-1:0]       i_adv,
  input  logic               i_load,
  input  logic [W-1:0]       i_load_state,
  input  logic [DWELL_W-1:0] i_timeout_cyc,
  output logic [W-1:0]       o_state,
  output logic [W-1:0]       o_next,
  output logic [N-1:0]       o_onehot,
  output logic               o_wrap,
  output logic [DWELL_W-1:0] o_dwell
);

  localparam logic [W-1:0] LAST_STATE  = W'(N - 1);
  // One extra bit so N = 2**W still compares correctly.
  localparam logic [W:0]   N_EXT       = (W+1)'(N);
  localparam logic [N-1:0] ONEHOT_RST  = N'(1);

  logic [W-1:0]       r_state;
  logic [N-1:0]       r_onehot;
  logic               r_wrap;

  cause_e             w_cause;
  logic [W-1:0]       w_succ;
  logic [W-1:0]       w_next;
  logic [N-1:0]       w_onehot_next;
  logic               w_wrap_next;
  logic               w_timeout;
  logic [DWELL_W-1:0] w_dwell;

`ifdef RING_FSM_TIMEOUT_EN
  logic w_dwell_clear;

  // Any non-hold cause either changes state or is a load, both restart dwell.
  assign w_dwell_clear = (w_cause != CAUSE_HOLD);

  ring_fsm_dwell #(
    .DWELL_W(DWELL_W)
  ) u_dwell (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_en         (i_en),
    .i_clear      (w_dwell_clear),
    .i_timeout_cyc(i_timeout_cyc),
    .o_timeout    (w_timeout),
    .o_dwell      (w_dwell)
  );
`else
  logic w_unused_timeout_cyc;

  assign w_unused_timeout_cyc = ^i_timeout_cyc;
  assign w_timeout            = 1'b0;
  assign w_dwell              = {DWELL_W{1'b0}};
`endif

  // Transition cause in priority order.
  always_comb begin
    w_cause = CAUSE_HOLD;
    if (!i_en) begin
      w_cause = CAUSE_HOLD;
    end else if (i_load) begin
      w_cause = CAUSE_LOAD;
    end else if (i_adv[r_state]) begin
      w_cause = CAUSE_ADV;
    end else if (w_timeout) begin
      w_cause = CAUSE_TIMEOUT;
    end else begin
      w_cause = CAUSE_HOLD;
    end
  end

  assign w_succ = (r_state == LAST_STATE) ? {W{1'b0}} : (r_state + W'(1));

  // Next-state mux driven by the cause.
  always_comb begin
    w_next = r_state;
    case (w_cause)
      CAUSE_LOAD: begin
        if ({1'b0, i_load_state} < N_EXT) begin
          w_next = i_load_state;
        end else begin
          w_next = {W{1'b0}};
        end
      end
      CAUSE_ADV, CAUSE_TIMEOUT: w_next = w_succ;
      CAUSE_HOLD:               w_next = r_state;
      default:                  w_next = r_state;
    endcase
  end

  // One-hot decode of the next state so the registered decode tracks state.
  always_comb begin
    w_onehot_next         = {N{1'b0}};
    w_onehot_next[w_next] = 1'b1;
  end

  // Only an advance out of the last state wraps; loads never do.
  assign w_wrap_next = ((w_cause == CAUSE_ADV) || (w_cause == CAUSE_TIMEOUT)) &&
                       (r_state == LAST_STATE);

  // State, decode and wrap registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= {W{1'b0}};
      r_onehot <= ONEHOT_RST;
      r_wrap   <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_onehot <= w_onehot_next;
      r_wrap   <= w_wrap_next;
    end
  end

  assign o_state  = r_state;
  assign o_next   = w_next;
  assign o_onehot = r_onehot;
  assign o_wrap   = r_wrap;
  assign o_dwell  = w_dwell;

endmodule

// File: tb/tb_ring_fsm.sv
// -----------------------------------------------------------------------------
// tb_ring_fsm
// Self-checking bench for ring_fsm. Two instances (N=3 and N=5) run side by
// side; a behavioural model written from the sequencing rules predicts every
// output each cycle.
// -----------------------------------------------------------------------------
module tb_ring_fsm;

`ifdef RING_FSM_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct packed {
    int st;
    int dw;
    bit wr;
  } ms_t;

  logic clk;
  logic rst_n;

  // Instance A: N=3
  logic       a_en, a_load, a_wrap;
  logic [2:0] a_adv, a_onehot;
  logic [1:0] a_ls, a_state, a_next;
  logic [7:0] a_tc, a_dwell;
  // Instance B: N=5
  logic       b_en, b_load, b_wrap;
  logic [4:0] b_adv, b_onehot;
  logic [2:0] b_ls, b_state, b_next;
  logic [7:0] b_tc, b_dwell;

  ms_t  ma, mb, ea, eb;
  logic [1:0] a_next_seen;
  logic [2:0] b_next_seen;

  int errors = 0;
  int checks = 0;

  ring_fsm #(.N(3)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(a_en), .i_adv(a_adv), .i_load(a_load),
    .i_load_state(a_ls), .i_timeout_cyc(a_tc), .o_state(a_state), .o_next(a_next),
    .o_onehot(a_onehot), .o_wrap(a_wrap), .o_dwell(a_dwell)
  );

  ring_fsm #(.N(5)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(b_en), .i_adv(b_adv), .i_load(b_load),
    .i_load_state(b_ls), .i_timeout_cyc(b_tc), .o_state(b_state), .o_next(b_next),
    .o_onehot(b_onehot), .o_wrap(b_wrap), .o_dwell(b_dwell)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one clock of the ring rules for an n-state ring.
  function automatic ms_t model_step(input int n, input ms_t cur, input bit en,
                                     input logic [4:0] adv, input bit load,
                                     input int ls, input int tc);
    ms_t nx;
    bit  fire;
    nx    = cur;
    nx.wr = 1'b0;
    if (!en) return nx;
    fire = TO_EN && (tc != 0) && (cur.dw == tc - 1);
    if (load) begin
      nx.st = (ls < n) ? ls : 0;
      nx.dw = 0;
    end else if (adv[cur.st] || fire) begin
      nx.st = (cur.st + 1) % n;
      nx.wr = (cur.st == n - 1);
      nx.dw = 0;
    end else if (TO_EN) begin
      nx.dw = (cur.dw < 255) ? cur.dw + 1 : 255;
    end
    return nx;
  endfunction

  // Advance both instances and both models by one clock with current inputs.
  task automatic tick;
    #1;
    ea = model_step(3, ma, a_en, {2'b00, a_adv}, a_load, int'(a_ls), int'(a_tc));
    eb = model_step(5, mb, b_en, b_adv, b_load, int'(b_ls), int'(b_tc));
    a_next_seen = a_next;
    b_next_seen = b_next;
    @(posedge clk);
    #1;
    ma = ea;
    mb = eb;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    a_en = 1'b0; a_adv = 3'b000; a_load = 1'b0; a_ls = 2'd0; a_tc = 8'd0;
    b_en = 1'b0; b_adv = 5'b00000; b_load = 1'b0; b_ls = 3'd0; b_tc = 8'd0;
    ma = '0; mb = '0;
    #12;
    checks++; if (a_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", a_state); end
    checks++; if (a_onehot !== 3'b001) begin errors++; $display("FAIL reset_onehot: got %b want 001", a_onehot); end
    checks++; if (a_wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %b want 0", a_wrap); end
    checks++; if (a_dwell !== 8'd0) begin errors++; $display("FAIL reset_dwell: got %0d want 0", a_dwell); end
    checks++; if (b_onehot !== 5'b00001) begin errors++; $display("FAIL reset_onehot_b: got %b want 00001", b_onehot); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_sequence;
    logic [2:0] advs [4] = '{3'b001, 3'b010, 3'b100, 3'b000};
    int         st   [4] = '{1, 2, 0, 0};
    logic       wr   [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    a_en = 1'b1; a_tc = 8'd0; a_load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_adv = advs[i];
      tick;
      checks++; if (a_next_seen !== 2'(st[i])) begin errors++; $display("FAIL seq_next[%0d]: got %0d want %0d", i, a_next_seen, st[i]); end
      checks++; if (a_state !== 2'(st[i])) begin errors++; $display("FAIL seq_state[%0d]: got %0d want %0d", i, a_state, st[i]); end
      checks++; if (a_onehot !== 3'(32'd1 << st[i])) begin errors++; $display("FAIL seq_onehot[%0d]: got %b", i, a_onehot); end
      checks++; if (a_wrap !== wr[i]) begin errors++; $display("FAIL seq_wrap[%0d]: got %b want %b", i, a_wrap, wr[i]); end
    end
  endtask

  task automatic test_masking;
    a_en = 1'b1; a_tc = 8'd0; a_adv = 3'b000;
    a_load = 1'b1; a_ls = 2'd1;
    tick;
    a_load = 1'b0;
    a_adv  = 3'b101;
    for (int i = 0; i < 4; i++) begin
      checks++; if (a_dwell !== 8'(ma.dw)) begin errors++; $display("FAIL mask_dwell[%0d]: got %0d want %0d", i, a_dwell, ma.dw); end
      tick;
      checks++; if (a_state !== 2'd1) begin errors++; $display("FAIL mask_state[%0d]: got %0d want 1", i, a_state); end
    end
    a_adv = 3'b000;
  endtask

  task automatic test_load;
    b_en = 1'b1; b_tc = 8'd0; b_adv = 5'b00000;
    b_load = 1'b1; b_ls = 3'd2;
    tick;
    checks++; if (b_state !== 3'd2) begin errors++; $display("FAIL load_to2: got %0d want 2", b_state); end
    b_ls = 3'd4; b_adv = 5'b00100;
    tick;
    checks++; if (b_state !== 3'd4) begin errors++; $display("FAIL load_prio: got %0d want 4", b_state); end
    checks++; if (b_onehot !== 5'b10000) begin errors++; $display("FAIL load_onehot: got %b want 10000", b_onehot); end
    b_ls = 3'd6; b_adv = 5'b00000;
    tick;
    checks++; if (b_state !== 3'd0) begin errors++; $display("FAIL load_oor: got %0d want 0", b_state); end
    checks++; if (b_wrap !== 1'b0) begin errors++; $display("FAIL load_nowrap: got %b want 0", b_wrap); end
    checks++; if (b_dwell !== 8'd0) begin errors++; $display("FAIL load_dwell: got %0d want 0", b_dwell); end
    b_load = 1'b0; b_en = 1'b0;
  endtask

  task automatic test_enable_hold;
    a_en = 1'b1; a_tc = 8'd0; a_adv = 3'b000;
    a_load = 1'b1; a_ls = 2'd1;
    tick;
    tick;
    a_load = 1'b0; a_en = 1'b0; a_adv = 3'b111;
    for (int i = 0; i < 5; i++) begin
      tick;
      checks++; if (a_state !== 2'd1) begin errors++; $display("FAIL hold_state[%0d]: got %0d want 1", i, a_state); end
      checks++; if (a_dwell !== 8'(ma.dw)) begin errors++; $display("FAIL hold_dwell[%0d]: got %0d want %0d", i, a_dwell, ma.dw); end
      checks++; if (a_next_seen !== 2'd1) begin errors++; $display("FAIL hold_next[%0d]: got %0d want 1", i, a_next_seen); end
    end
    a_en = 1'b1;
    tick;
    checks++; if (a_state !== 2'd2) begin errors++; $display("FAIL hold_release: got %0d want 2", a_state); end
    a_adv = 3'b000;
  endtask

  task automatic test_timeout;
    a_en = 1'b1; a_adv = 3'b000; a_tc = 8'd0;
    a_load = 1'b1; a_ls = 2'd0;
    tick;
    a_load = 1'b0; a_tc = 8'd3;
    for (int i = 0; i < 10; i++) begin
      tick;
      checks++; if (a_state !== 2'(ma.st)) begin errors++; $display("FAIL to3_state[%0d]: got %0d want %0d", i, a_state, ma.st); end
      checks++; if (a_wrap !== ma.wr) begin errors++; $display("FAIL to3_wrap[%0d]: got %b want %b", i, a_wrap, ma.wr); end
    end
    a_tc = 8'd0;
    for (int i = 0; i < 8; i++) begin
      tick;
      checks++; if (a_state !== 2'(ma.st)) begin errors++; $display("FAIL to0_state[%0d]: got %0d want %0d", i, a_state, ma.st); end
    end
    a_tc = 8'd1;
    for (int i = 0; i < 4; i++) begin
      tick;
      checks++; if (a_state !== 2'(ma.st)) begin errors++; $display("FAIL to1_state[%0d]: got %0d want %0d", i, a_state, ma.st); end
      checks++; if (a_dwell !== 8'(ma.dw)) begin errors++; $display("FAIL to1_dwell[%0d]: got %0d want %0d", i, a_dwell, ma.dw); end
    end
    a_tc = 8'd0;
  endtask

  task automatic test_saturation;
    a_en = 1'b1; a_adv = 3'b000; a_tc = 8'd0; a_load = 1'b0;
    for (int i = 0; i < 270; i++) begin
      tick;
      checks++; if (a_dwell !== 8'(ma.dw)) begin errors++; $display("FAIL sat_dwell[%0d]: got %0d want %0d", i, a_dwell, ma.dw); end
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 400; i++) begin
      a_en = ($urandom_range(0, 7) != 0); a_adv = 3'($urandom); a_load = ($urandom_range(0, 7) == 0);
      a_ls = 2'($urandom); a_tc = 8'($urandom_range(0, 4));
      b_en = ($urandom_range(0, 7) != 0); b_adv = 5'($urandom); b_load = ($urandom_range(0, 7) == 0);
      b_ls = 3'($urandom); b_tc = 8'($urandom_range(0, 6));
      tick;
      checks++; if (a_next_seen !== 2'(ma.st)) begin errors++; $display("FAIL rnd_a_next[%0d]: got %0d want %0d", i, a_next_seen, ma.st); end
      checks++; if (a_state !== 2'(ma.st)) begin errors++; $display("FAIL rnd_a_state[%0d]: got %0d want %0d", i, a_state, ma.st); end
      checks++; if (a_onehot !== 3'(32'd1 << ma.st)) begin errors++; $display("FAIL rnd_a_onehot[%0d]: got %b", i, a_onehot); end
      checks++; if (a_wrap !== ma.wr) begin errors++; $display("FAIL rnd_a_wrap[%0d]: got %b want %b", i, a_wrap, ma.wr); end
      checks++; if (a_dwell !== 8'(ma.dw)) begin errors++; $display("FAIL rnd_a_dwell[%0d]: got %0d want %0d", i, a_dwell, ma.dw); end
      checks++; if (b_next_seen !== 3'(mb.st)) begin errors++; $display("FAIL rnd_b_next[%0d]: got %0d want %0d", i, b_next_seen, mb.st); end
      checks++; if (b_state !== 3'(mb.st)) begin errors++; $display("FAIL rnd_b_state[%0d]: got %0d want %0d", i, b_state, mb.st); end
      checks++; if (b_onehot !== 5'(32'd1 << mb.st)) begin errors++; $display("FAIL rnd_b_onehot[%0d]: got %b", i, b_onehot); end
      checks++; if (b_wrap !== mb.wr) begin errors++; $display("FAIL rnd_b_wrap[%0d]: got %b want %b", i, b_wrap, mb.wr); end
      checks++; if (b_dwell !== 8'(mb.dw)) begin errors++; $display("FAIL rnd_b_dwell[%0d]: got %0d want %0d", i, b_dwell, mb.dw); end
    end
  endtask

  task automatic test_reset_mid;
    a_en = 1'b1; a_adv = 3'b000; a_tc = 8'd0; a_load = 1'b1; a_ls = 2'd2;
    b_en = 1'b1; b_adv = 5'b00000; b_tc = 8'd0; b_load = 1'b1; b_ls = 3'd4;
    tick;
    a_load = 1'b0; b_load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      b_adv = (i == 4) ? 5'b10000 : 5'b00000;
      tick;
    end
    checks++; if (a_state !== 2'd2) begin errors++; $display("FAIL mid_pre_state: got %0d want 2", a_state); end
    checks++; if (a_dwell !== 8'(ma.dw)) begin errors++; $display("FAIL mid_pre_dwell: got %0d want %0d", a_dwell, ma.dw); end
    checks++; if (b_wrap !== 1'b1) begin errors++; $display("FAIL mid_pre_wrap: got %b want 1", b_wrap); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (a_state !== 2'd0) begin errors++; $display("FAIL mid_state: got %0d want 0", a_state); end
    checks++; if (a_onehot !== 3'b001) begin errors++; $display("FAIL mid_onehot: got %b want 001", a_onehot); end
    checks++; if (a_dwell !== 8'd0) begin errors++; $display("FAIL mid_dwell: got %0d want 0", a_dwell); end
    checks++; if (b_wrap !== 1'b0) begin errors++; $display("FAIL mid_wrap: got %b want 0", b_wrap); end
    checks++; if (b_state !== 3'd0) begin errors++; $display("FAIL mid_state_b: got %0d want 0", b_state); end
    ma = '0; mb = '0;
    a_en = 1'b0; b_en = 1'b0; b_adv = 5'b00000;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset;
    test_sequence;
    test_masking;
    test_load;
    test_enable_hold;
    test_timeout;
    test_saturation;
    test_random;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
